// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and a magnitude helper for the
// iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_OP_NOP   = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MTHI  = 3'd5,
        MD_OP_MTLO  = 3'd6,
        MD_OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2
    } md_state_e;

    localparam int unsigned MD_ITERS = 32;

    // Two's-complement magnitude; 80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the decoder (master) and the muldiv unit (slave).
interface muldiv_if;
    // Handshake: the master pulses start for one cycle with op/a/b; it is taken
    // only while busy=0. Iterative ops raise busy until a one-cycle done pulse,
    // at which point hi/lo carry the result. MTHI/MTLO complete silently.
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a final cycle.
module muldiv
    import muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output md_state_e  dbg_state
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        is_div_q, is_div_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        div0_q, div0_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    md_op_e      op_e;
    logic        signed_op;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        ge;
    logic [63:0] prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        dvsr_d    = dvsr_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_e      = md_op_e'(bus.op);
        signed_op = (op_e == MD_OP_MULT) || (op_e == MD_OP_DIV);
        sum       = 33'd0;
        rem_sh    = 33'd0;
        ge        = 1'b0;
        prod      = 64'd0;

        case (state_q)
            MD_ST_IDLE: begin
                if (bus.start) begin
                    case (op_e)
                        MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                            sh_d     = signed_op ? abs32(bus.a) : bus.a;
                            dvsr_d   = signed_op ? abs32(bus.b) : bus.b;
                            neg_q_d  = signed_op & (bus.a[31] ^ bus.b[31]);
                            neg_r_d  = signed_op & bus.a[31];
                            is_div_d = (op_e == MD_OP_DIV) || (op_e == MD_OP_DIVU);
                            div0_d   = (bus.b == 32'd0);
                            a_raw_d  = bus.a;
                            acc_d    = 64'd0;
                            cnt_d    = 5'd0;
                            busy_d   = 1'b1;
                            state_d  = MD_ST_CALC;
                        end
                        MD_OP_MTHI: hi_d = bus.a;
                        MD_OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            MD_ST_CALC: begin
                if (is_div_q) begin
                    // acc = {quotient, partial remainder}; dividend bits come from sh MSB first.
                    rem_sh = {acc_q[31:0], sh_q[31]};
                    ge     = (rem_sh >= {1'b0, dvsr_q});
                    acc_d  = {acc_q[62:32], ge, ge ? (rem_sh[31:0] - dvsr_q) : rem_sh[31:0]};
                    sh_d   = {sh_q[30:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_q[63:32]} + (sh_q[0] ? {1'b0, dvsr_q} : 33'd0);
                    acc_d = {sum, acc_q[31:1]};
                    sh_d  = {1'b0, sh_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MD_ITERS - 1)) begin
                    state_d = MD_ST_FIX;
                end
            end
            MD_ST_FIX: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = neg_q_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                        hi_d = neg_r_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    end
                end else begin
                    prod = neg_q_q ? (~acc_q + 64'd1) : acc_q;
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = MD_ST_IDLE;
            end
            default: begin
                state_d = MD_ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_ST_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            sh_q     <= 32'd0;
            dvsr_q   <= 32'd0;
            a_raw_q  <= 32'd0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            dvsr_q   <= dvsr_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = state_q;

endmodule
